// File: rtl/memory_access_unit_if.sv
// memory_access_unit_if: execute bundle, data-memory bus and write-back bundle.
// slave = memory stage side; master = surrounding pipeline and memory side.
interface memory_access_unit_if #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
);
    logic             valid_in;
    logic             ready_out;
    logic             mem_read;
    logic             mem_write;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd_index_in;
    logic             need_write_rd_in;
    logic [XLEN-1:0]  pc_next_in;

    logic             dmem_req;
    logic             dmem_we;
    logic [XLEN-1:0]  dmem_addr;
    logic [XLEN-1:0]  dmem_wdata;
    logic [3:0]       dmem_wstrb;
    logic             dmem_ack;
    logic [XLEN-1:0]  dmem_rdata;

    logic             wb_valid;
    logic [REG_W-1:0] rd_index;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  pc_next;
    logic             need_write_rd;
    logic             mem_fault;

    modport slave (
        input  valid_in,
        output ready_out,
        input  mem_read,
        input  mem_write,
        input  funct3,
        input  alu_result,
        input  store_data,
        input  rd_index_in,
        input  need_write_rd_in,
        input  pc_next_in,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata,
        output wb_valid,
        output rd_index,
        output result,
        output pc_next,
        output need_write_rd,
        output mem_fault
    );

    modport master (
        output valid_in,
        input  ready_out,
        output mem_read,
        output mem_write,
        output funct3,
        output alu_result,
        output store_data,
        output rd_index_in,
        output need_write_rd_in,
        output pc_next_in,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata,
        input  wb_valid,
        input  rd_index,
        input  result,
        input  pc_next,
        input  need_write_rd,
        input  mem_fault
    );
endinterface

// File: rtl/memory_access_unit.sv
// memory_access_unit: rv32 memory stage, one req/ack data-bus transaction per load/store.
// Define MEM_TIMEOUT_EN to add a bus watchdog that gives up after TIMEOUT_CYCLES.
module memory_access_unit #(
    parameter int XLEN           = 32,
    parameter int REG_W          = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    memory_access_unit_if.slave io_bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_addr;
    logic [2:0]       r_f3;
    logic             r_we;
    logic [3:0]       r_wstrb;
    logic [XLEN-1:0]  r_wdata;
    logic             r_need_pend;
    logic             r_wb_valid;
    logic [XLEN-1:0]  r_result;
    logic [REG_W-1:0] r_rd;
    logic [XLEN-1:0]  r_pc;
    logic             r_need;
    logic             r_fault;

    logic             w_accept;
    logic             w_is_mem;
    logic             w_f3_bad;
    logic             w_misal;
    logic             w_fault;
    logic             w_timeout;
    logic [XLEN-1:0]  w_st_data;
    logic [3:0]       w_st_strb;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_ld_data;

    assign w_accept = io_bus.valid_in & (r_state == S_IDLE);
    assign w_is_mem = io_bus.mem_read | io_bus.mem_write;

    // Read and write together is reported like an illegal funct3.
    always_comb begin
        w_f3_bad = 1'b0;
        if (io_bus.mem_read & io_bus.mem_write) begin
            w_f3_bad = 1'b1;
        end else if (io_bus.mem_read) begin
            w_f3_bad = (io_bus.funct3 == 3'b011) |
                       (io_bus.funct3[2:1] == 2'b11);
        end else if (io_bus.mem_write) begin
            w_f3_bad = io_bus.funct3[2] | (&io_bus.funct3[1:0]);
        end
    end

    always_comb begin
        w_misal = 1'b0;
        unique case (io_bus.funct3[1:0])
            2'b01:   w_misal = io_bus.alu_result[0];
            2'b10:   w_misal = |io_bus.alu_result[1:0];
            default: w_misal = 1'b0;
        endcase
    end

    assign w_fault = w_is_mem & (w_f3_bad | w_misal);

    always_comb begin
        w_st_data = io_bus.store_data;
        w_st_strb = 4'b1111;
        unique case (1'b1)
            io_bus.funct3[1:0] == 2'b00: begin
                w_st_data = {(XLEN/8){io_bus.store_data[7:0]}};
                w_st_strb = 4'b0001 << io_bus.alu_result[1:0];
            end
            io_bus.funct3[1:0] == 2'b01: begin
                w_st_data = {(XLEN/16){io_bus.store_data[15:0]}};
                w_st_strb = io_bus.alu_result[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_st_data = io_bus.store_data;
                w_st_strb = 4'b1111;
            end
        endcase
    end

    assign w_byte = io_bus.dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = io_bus.dmem_rdata[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_data = io_bus.dmem_rdata;
        unique case (r_f3)
            3'b000:  w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_ld_data = io_bus.dmem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_to_cnt;

    // Counter sits at zero outside BUS, so each transaction starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_BUS) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_to_cnt == LP_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_f3        <= '0;
            r_we        <= 1'b0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_need_pend <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_pc        <= '0;
            r_need      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd <= io_bus.rd_index_in;
                        r_pc <= io_bus.pc_next_in;
                        if (!w_is_mem || w_fault) begin
                            r_result   <= io_bus.alu_result;
                            r_need     <= io_bus.need_write_rd_in & ~w_fault;
                            r_fault    <= w_fault;
                            r_wb_valid <= 1'b1;
                        end else begin
                            r_addr      <= io_bus.alu_result;
                            r_f3        <= io_bus.funct3;
                            r_need_pend <= io_bus.need_write_rd_in;
                            r_we        <= io_bus.mem_write;
                            r_wstrb     <= io_bus.mem_write ? w_st_strb : 4'b0000;
                            r_wdata     <= io_bus.mem_write ? w_st_data : '0;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // An ack in the same cycle as the watchdog limit wins.
                    if (io_bus.dmem_ack || w_timeout) begin
                        r_result   <= (r_we || !io_bus.dmem_ack) ? r_addr : w_ld_data;
                        r_need     <= r_need_pend & io_bus.dmem_ack;
                        r_fault    <= ~io_bus.dmem_ack;
                        r_wb_valid <= 1'b1;
                        r_we       <= 1'b0;
                        r_wstrb    <= 4'b0000;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.ready_out     = (r_state == S_IDLE);
    assign io_bus.dmem_req      = (r_state == S_BUS);
    assign io_bus.dmem_we       = r_we;
    assign io_bus.dmem_addr     = {r_addr[XLEN-1:2], 2'b00};
    assign io_bus.dmem_wdata    = r_wdata;
    assign io_bus.dmem_wstrb    = r_wstrb;
    assign io_bus.wb_valid      = r_wb_valid;
    assign io_bus.rd_index      = r_rd;
    assign io_bus.result        = r_result;
    assign io_bus.pc_next       = r_pc;
    assign io_bus.need_write_rd = r_need;
    assign io_bus.mem_fault     = r_fault;

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed and randomized checks of the memory stage
// against a byte-level reference model and a small word memory.
module tb_memory_access_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    memory_access_unit_if #(.XLEN(32), .REG_W(5)) vif ();

    memory_access_unit #(
        .XLEN(32),
        .REG_W(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem;
        logic        fault;
        logic        we;
        logic        need;
        logic [31:0] result;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        ob_wb, ob_need, ob_fault, ob_we, ob_stable, ob_busy_ok;
    logic        ob_wb_after, ob_rdy_after;
    logic [4:0]  ob_rd;
    logic [31:0] ob_result, ob_pc, ob_addr, ob_wdata;
    logic [3:0]  ob_wstrb;
    int          ob_req_cyc;
    logic [31:0] mem [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic rd_, input logic wr_, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] sd,
                                   input logic nw, input logic [31:0] rdata);
        exp_t        e;
        int          nb;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        e.mem    = rd_ | wr_;
        e.we     = wr_;
        e.fault  = 1'b0;
        e.wdata  = 32'h0;
        e.wstrb  = 4'h0;
        nb       = 1 << f3[1:0];
        sh       = 8 * int'(addr[1:0]);
        if (rd_ && wr_) e.fault = 1'b1;
        else if (rd_) e.fault = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (wr_) e.fault = !(f3 inside {3'd0, 3'd1, 3'd2});
        if (e.mem && !e.fault && (int'(addr[1:0]) % nb) != 0) e.fault = 1'b1;
        mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        if (!rd_) begin
            e.result = addr;
        end else begin
            v = (rdata >> sh) & mask;
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e.result = v;
        end
        if (wr_ && !rd_ && nb <= 4) begin
            if (nb == 1) e.wdata = (sd & 32'hFF) * 32'h0101_0101;
            else if (nb == 2) e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
            else e.wdata = sd;
            e.wstrb = 4'(((1 << nb) - 1) << addr[1:0]);
        end
        e.need = nw & ~e.fault;
        return e;
    endfunction

    task automatic run_op(input logic rd_, input logic wr_, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] ri, input logic nw, input logic [31:0] pcn,
                          input logic [31:0] rdata, input int waitc);
        vif.valid_in         = 1'b1;
        vif.mem_read         = rd_;
        vif.mem_write        = wr_;
        vif.funct3           = f3;
        vif.alu_result       = addr;
        vif.store_data       = sd;
        vif.rd_index_in      = ri;
        vif.need_write_rd_in = nw;
        vif.pc_next_in       = pcn;
        tick();
        vif.valid_in   = 1'b0;
        vif.alu_result = $urandom();
        vif.store_data = $urandom();
        ob_req_cyc = 0;
        ob_stable  = 1'b1;
        ob_busy_ok = 1'b1;
        ob_addr    = vif.dmem_addr;
        ob_we      = vif.dmem_we;
        ob_wstrb   = vif.dmem_wstrb;
        ob_wdata   = vif.dmem_wdata;
        while (vif.dmem_req === 1'b1 && ob_req_cyc < 40) begin
            if (vif.dmem_addr !== ob_addr || vif.dmem_we !== ob_we ||
                vif.dmem_wstrb !== ob_wstrb || vif.dmem_wdata !== ob_wdata)
                ob_stable = 1'b0;
            if (vif.ready_out !== 1'b0 || vif.wb_valid !== 1'b0) ob_busy_ok = 1'b0;
            vif.dmem_ack   = (ob_req_cyc == waitc);
            vif.dmem_rdata = (ob_req_cyc == waitc) ? rdata : $urandom();
            ob_req_cyc++;
            tick();
        end
        vif.dmem_ack = 1'b0;
        ob_wb     = vif.wb_valid;
        ob_result = vif.result;
        ob_rd     = vif.rd_index;
        ob_pc     = vif.pc_next;
        ob_need   = vif.need_write_rd;
        ob_fault  = vif.mem_fault;
        tick();
        ob_wb_after  = vif.wb_valid;
        ob_rdy_after = vif.ready_out;
    endtask

    task automatic check_op(input string tag, input exp_t e, input int waitc,
                            input logic [31:0] addr, input logic [4:0] ri,
                            input logic [31:0] pcn);
        int ncyc;
        ncyc = (e.mem && !e.fault) ? waitc + 1 : 0;
        chk({tag, ".wb"}, 32'(ob_wb), 32'd1);
        chk({tag, ".rd"}, 32'(ob_rd), 32'(ri));
        chk({tag, ".pc"}, ob_pc, pcn);
        chk({tag, ".need"}, 32'(ob_need), 32'(e.need));
        chk({tag, ".fault"}, 32'(ob_fault), 32'(e.fault));
        if (!e.fault) chk({tag, ".result"}, ob_result, e.result);
        chk({tag, ".reqcyc"}, 32'(ob_req_cyc), 32'(ncyc));
        if (ncyc > 0) begin
            chk({tag, ".addr"}, ob_addr, addr & 32'hFFFF_FFFC);
            chk({tag, ".we"}, 32'(ob_we), 32'(e.we));
            chk({tag, ".wstrb"}, 32'(ob_wstrb), 32'(e.wstrb));
            if (e.we) chk({tag, ".wdata"}, ob_wdata, e.wdata);
            chk({tag, ".stable"}, 32'(ob_stable), 32'd1);
            chk({tag, ".busy"}, 32'(ob_busy_ok), 32'd1);
        end
        chk({tag, ".wb_after"}, 32'(ob_wb_after), 32'd0);
        chk({tag, ".rdy_after"}, 32'(ob_rdy_after), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic        rd_, wr_, nw;
        logic [2:0]  f3;
        logic [31:0] addr, sd, rdata, pcn;
        logic [4:0]  ri;
        int          k, waitc, nb;
        logic [2:0]  ld_ok [5];

        ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 16; i++) mem[i] = $urandom();

        rst_n                = 1'b0;
        vif.valid_in         = 1'b0;
        vif.mem_read         = 1'b0;
        vif.mem_write        = 1'b0;
        vif.funct3           = 3'd0;
        vif.alu_result       = 32'h0;
        vif.store_data       = 32'h0;
        vif.rd_index_in      = 5'd0;
        vif.need_write_rd_in = 1'b0;
        vif.pc_next_in       = 32'h0;
        vif.dmem_ack         = 1'b0;
        vif.dmem_rdata       = 32'h0;
        tick();
        tick();
        chk("rst.ready", 32'(vif.ready_out), 32'd1);
        chk("rst.req", 32'(vif.dmem_req), 32'd0);
        chk("rst.we", 32'(vif.dmem_we), 32'd0);
        chk("rst.wstrb", 32'(vif.dmem_wstrb), 32'd0);
        chk("rst.wb", 32'(vif.wb_valid), 32'd0);
        chk("rst.fault", 32'(vif.mem_fault), 32'd0);
        chk("rst.need", 32'(vif.need_write_rd), 32'd0);
        chk("rst.addr", vif.dmem_addr, 32'h0);
        chk("rst.result", vif.result, 32'h0);
        chk("rst.pc", vif.pc_next, 32'h0);
        chk("rst.rd", 32'(vif.rd_index), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h40, 32'h0, 0);
        e = model(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 1'b1, 32'h0);
        check_op("add", e, 0, 32'h0000_1234, 5'd5, 32'h40);
        chk("add.result_k", ob_result, 32'h0000_1234);

        vif.valid_in   = 1'b1;
        vif.mem_read   = 1'b0;
        vif.mem_write  = 1'b0;
        vif.alu_result = 32'hAAAA_0001;
        vif.rd_index_in = 5'd9;
        tick();
        chk("b2b.wb1", 32'(vif.wb_valid), 32'd1);
        chk("b2b.res1", vif.result, 32'hAAAA_0001);
        chk("b2b.rdy1", 32'(vif.ready_out), 32'd1);
        vif.alu_result  = 32'hBBBB_0002;
        vif.rd_index_in = 5'd10;
        tick();
        chk("b2b.wb2", 32'(vif.wb_valid), 32'd1);
        chk("b2b.res2", vif.result, 32'hBBBB_0002);
        chk("b2b.rd2", 32'(vif.rd_index), 32'd10);
        vif.valid_in = 1'b0;
        tick();
        chk("b2b.wb3", 32'(vif.wb_valid), 32'd0);

        run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 32'h44, 32'h80AB_CDEF, 2);
        e = model(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 32'h80AB_CDEF);
        check_op("lb", e, 2, 32'h103, 5'd7, 32'h44);
        chk("lb.result_k", ob_result, 32'hFFFF_FF80);
        chk("lb.addr_k", ob_addr, 32'h100);

        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 1'b1, 32'h48, 32'h80AB_CDEF, 2);
        e = model(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b1, 32'h80AB_CDEF);
        check_op("lbu", e, 2, 32'h103, 5'd8, 32'h48);
        chk("lbu.result_k", ob_result, 32'h0000_0080);

        run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 5'd0, 1'b0, 32'h4C, 32'h0, 1);
        e = model(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 1'b0, 32'h0);
        check_op("sh", e, 1, 32'h202, 5'd0, 32'h4C);
        chk("sh.we_k", 32'(ob_we), 32'd1);
        chk("sh.wdata_k", ob_wdata, 32'h5678_5678);
        chk("sh.wstrb_k", 32'(ob_wstrb), 32'hC);

        run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 1'b1, 32'h50, 32'h0, 0);
        e = model(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 32'h0);
        check_op("lw_mis", e, 0, 32'h101, 5'd3, 32'h50);
        chk("lw_mis.fault_k", 32'(ob_fault), 32'd1);
        chk("lw_mis.need_k", 32'(ob_need), 32'd0);

        run_op(1'b1, 1'b1, 3'b010, 32'h200, 32'h0, 5'd4, 1'b1, 32'h54, 32'h0, 0);
        chk("rw.fault_k", 32'(ob_fault), 32'd1);
        chk("rw.reqcyc_k", 32'(ob_req_cyc), 32'd0);

        vif.dmem_ack = 1'b1;
        tick();
        vif.dmem_ack = 1'b0;
        chk("stray_ack.wb", 32'(vif.wb_valid), 32'd0);
        chk("stray_ack.req", 32'(vif.dmem_req), 32'd0);
        chk("stray_ack.rdy", 32'(vif.ready_out), 32'd1);

        vif.valid_in   = 1'b1;
        vif.mem_read   = 1'b1;
        vif.mem_write  = 1'b0;
        vif.funct3     = 3'b010;
        vif.alu_result = 32'h300;
        tick();
        vif.valid_in = 1'b0;
        chk("rstbus.req1", 32'(vif.dmem_req), 32'd1);
        vif.dmem_ack = 1'b1;
        rst_n        = 1'b0;
        tick();
        chk("rstbus.req0", 32'(vif.dmem_req), 32'd0);
        chk("rstbus.wb0", 32'(vif.wb_valid), 32'd0);
        chk("rstbus.rdy", 32'(vif.ready_out), 32'd1);
        rst_n        = 1'b1;
        vif.dmem_ack = 1'b0;
        tick();
        chk("rstbus.wb1", 32'(vif.wb_valid), 32'd0);
        chk("rstbus.req2", 32'(vif.dmem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd6, 1'b1, 32'h58, 32'h0, 1000);
        chk("tmo.reqcyc", 32'(ob_req_cyc), 32'd4);
        chk("tmo.wb", 32'(ob_wb), 32'd1);
        chk("tmo.fault", 32'(ob_fault), 32'd1);
        chk("tmo.need", 32'(ob_need), 32'd0);
        chk("tmo.rdy_after", 32'(ob_rdy_after), 32'd1);
`endif

        for (int i = 0; i < 60; i++) begin
            k     = $urandom_range(0, 9);
            rd_   = (k >= 2 && k <= 5) || k == 9;
            wr_   = (k >= 6);
            f3    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (rd_) f3 = ld_ok[$urandom_range(0, 4)];
                else if (wr_) f3 = 3'($urandom_range(0, 2));
            end
            addr  = $urandom();
            nb    = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0 && nb <= 4) addr = addr & ~32'(nb - 1);
            sd    = $urandom();
            ri    = 5'($urandom_range(0, 31));
            nw    = 1'($urandom_range(0, 1));
            pcn   = $urandom();
            waitc = $urandom_range(0, 3);
            rdata = mem[addr[5:2]];
            run_op(rd_, wr_, f3, addr, sd, ri, nw, pcn, rdata, waitc);
            e = model(rd_, wr_, f3, addr, sd, nw, rdata);
            check_op($sformatf("rnd%0d", i), e, waitc, addr, ri, pcn);
            if (wr_ && !rd_ && !e.fault) begin
                for (int b = 0; b < 4; b++)
                    if (e.wstrb[b]) mem[addr[5:2]][8*b +: 8] = e.wdata[8*b +: 8];
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
